// File: rtl/calculator_alu.sv
// rtl/calculator_alu.sv - multi-cycle ALU: single-cycle ADD/SUB, shift-add MUL and restoring DIV
module calculator_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_alu_input_a,
    input  logic [DATA_WIDTH-1:0] i_alu_input_b,
    input  logic [1:0]            i_alu_input_op,
    input  logic                  i_alu_input_signed,
    input  logic                  i_alu_input_valid,
    output logic                  o_alu_input_ready,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic                  o_alu_error,
    output logic                  o_alu_result_valid,
    input  logic                  i_alu_result_ready
);

    localparam int N = DATA_WIDTH;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam logic [N-1:0]   CNT_LAST = N'(N - 1);
    localparam logic [2*N-1:0] POS_LIM  = {{(N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic [2*N-1:0] NEG_LIM  = {{N{1'b0}}, 1'b1, {(N - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL_ITER, DIV_ITER, FINISH, DONE} state_t;

    state_t         state, state_next;
    logic [N-1:0]   mag_b, cnt, result_q;
    logic [2*N-1:0] acc;
    logic [1:0]     op_q;
    logic           error_q, sgn_q, neg_q, b_zero_q;

    logic [N-1:0]   abs_a, abs_b, div_rem;
    logic [N:0]     sum, diff, mul_sum, div_shift, div_trial;
    logic           add_err, sub_err, div_ge;
    logic [2*N-1:0] fin_mag;
    logic           fin_neg, fin_ovf, fin_err;
    logic [N-1:0]   fin_res;

    assign abs_a = (i_alu_input_signed && i_alu_input_a[N-1]) ? (~i_alu_input_a + N'(1)) : i_alu_input_a;
    assign abs_b = (i_alu_input_signed && i_alu_input_b[N-1]) ? (~i_alu_input_b + N'(1)) : i_alu_input_b;

    assign sum  = {1'b0, i_alu_input_a} + {1'b0, i_alu_input_b};
    assign diff = {1'b0, i_alu_input_a} - {1'b0, i_alu_input_b};
    assign add_err = i_alu_input_signed
                   ? ((i_alu_input_a[N-1] == i_alu_input_b[N-1]) && (sum[N-1] != i_alu_input_a[N-1]))
                   : sum[N];
    assign sub_err = i_alu_input_signed
                   ? ((i_alu_input_a[N-1] != i_alu_input_b[N-1]) && (diff[N-1] != i_alu_input_a[N-1]))
                   : diff[N];

    // acc = {partial product high, multiplier remaining} for MUL, {remainder, dividend/quotient} for DIV
    assign mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mag_b} : {(N + 1){1'b0}});
    assign div_shift = {acc[2*N-1:N], acc[N-1]};
    assign div_trial = div_shift - {1'b0, mag_b};
    assign div_ge    = ~div_trial[N];
    assign div_rem   = div_ge ? div_trial[N-1:0] : div_shift[N-1:0];

    assign fin_mag = (op_q == OP_MUL) ? acc : {{N{1'b0}}, acc[N-1:0]};
    assign fin_neg = neg_q && (fin_mag != '0);
    assign fin_ovf = sgn_q ? (fin_mag > (neg_q ? NEG_LIM : POS_LIM))
                           : ((op_q == OP_MUL) && (acc[2*N-1:N] != '0));
    assign fin_err = fin_ovf || ((op_q == OP_DIV) && b_zero_q);
    assign fin_res = fin_err ? '0 : (fin_neg ? (~fin_mag[N-1:0] + N'(1)) : fin_mag[N-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next         = state;
        o_alu_input_ready  = 1'b0;
        o_alu_result_valid = 1'b0;
        case (state)
            IDLE: begin
                o_alu_input_ready = 1'b1;
                if (i_alu_input_valid) begin
                    case (i_alu_input_op)
                        OP_MUL:  state_next = MUL_ITER;
                        OP_DIV:  state_next = DIV_ITER;
                        default: state_next = DONE;
                    endcase
                end
            end
            MUL_ITER, DIV_ITER: if (cnt == CNT_LAST) state_next = FINISH;
            FINISH: state_next = DONE;
            DONE: begin
                o_alu_result_valid = 1'b1;
                if (i_alu_result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_b    <= '0;
            cnt      <= '0;
            acc      <= '0;
            op_q     <= OP_ADD;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_alu_input_valid) begin
                    op_q     <= i_alu_input_op;
                    sgn_q    <= i_alu_input_signed;
                    neg_q    <= i_alu_input_signed && (i_alu_input_a[N-1] ^ i_alu_input_b[N-1]);
                    b_zero_q <= (i_alu_input_b == '0);
                    mag_b    <= abs_b;
                    acc      <= {{N{1'b0}}, abs_a};
                    cnt      <= '0;
                    if (i_alu_input_op == OP_ADD) begin
                        result_q <= add_err ? '0 : sum[N-1:0];
                        error_q  <= add_err;
                    end else if (i_alu_input_op == OP_SUB) begin
                        result_q <= sub_err ? '0 : diff[N-1:0];
                        error_q  <= sub_err;
                    end
                end
                MUL_ITER: begin
                    acc <= {mul_sum, acc[N-1:1]};
                    cnt <= cnt + N'(1);
                end
                DIV_ITER: begin
                    acc <= {div_rem, acc[N-2:0], div_ge};
                    cnt <= cnt + N'(1);
                end
                FINISH: begin
                    result_q <= fin_res;
                    error_q  <= fin_err;
                end
                default: ;
            endcase
        end
    end

    assign o_alu_result = result_q;
    assign o_alu_error  = error_q;

endmodule

// File: tb/tb_calculator_alu.sv
// tb/tb_calculator_alu.sv - self-checking bench for calculator_alu
module tb_calculator_alu;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  a = '0, b = '0;
    logic [1:0]    op = '0;
    logic          sgn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  result;
    logic          error;
    logic          res_valid;
    logic          res_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    calculator_alu #(.DATA_WIDTH(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_alu_input_a     (a),
        .i_alu_input_b     (b),
        .i_alu_input_op    (op),
        .i_alu_input_signed(sgn),
        .i_alu_input_valid (in_valid),
        .o_alu_input_ready (in_ready),
        .o_alu_result      (result),
        .o_alu_error       (error),
        .o_alu_result_valid(res_valid),
        .i_alu_result_ready(res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   op;
        logic         sgn;
        logic [N-1:0] res;
        logic         err;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: evaluate the true mathematical result and range-check it.
    task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic [1:0] mop,
                         input logic ms, output logic [N-1:0] r, output logic e);
        longint x, y, t, lo, hi;
        x = ms ? longint'($signed(ma)) : longint'(ma);
        y = ms ? longint'($signed(mb)) : longint'(mb);
        lo = ms ? -(longint'(1) << (N - 1)) : 0;
        hi = ms ? (longint'(1) << (N - 1)) - 1 : (longint'(1) << N) - 1;
        t = 0;
        e = 1'b0;
        case (mop)
            2'b00: t = x + y;
            2'b01: t = x - y;
            2'b10: t = x * y;
            default: if (y == 0) e = 1'b1; else t = x / y;
        endcase
        if (t < lo || t > hi) e = 1'b1;
        r = e ? '0 : t[N-1:0];
    endtask

    task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [1:0] iop,
                         input logic is, output logic [N-1:0] r, output logic e, output int lat);
        @(negedge clk);
        a = ia; b = ib; op = iop; sgn = is; in_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        e = error;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    function automatic logic [N-1:0] rand_val();
        logic [N-1:0] picks [5];
        picks[0] = 16'h0000; picks[1] = 16'h0001; picks[2] = 16'h7FFF;
        picks[3] = 16'h8000; picks[4] = 16'hFFFF;
        case ($urandom_range(0, 3))
            0:       return N'($urandom);
            1:       return N'($urandom_range(0, 20));
            2:       return picks[$urandom_range(0, 4)];
            default: return N'($urandom_range(0, 300)) ^ ($urandom_range(0, 1) ? 16'hFFFF : 16'h0000);
        endcase
    endfunction

    vec_t vecs [$];

    initial begin
        logic [N-1:0] r, mr;
        logic e, me;
        int lat;

        vecs.push_back('{16'd100,  16'd200,  2'b00, 1'b0, 16'd300,  1'b0, 1});
        vecs.push_back('{16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1'b1, 1});
        vecs.push_back('{16'h7FFF, 16'h0001, 2'b00, 1'b1, 16'h0000, 1'b1, 1});
        vecs.push_back('{16'd5,    16'd7,    2'b01, 1'b0, 16'h0000, 1'b1, 1});
        vecs.push_back('{16'd5,    16'd7,    2'b01, 1'b1, 16'hFFFE, 1'b0, 1});
        vecs.push_back('{16'h8000, 16'h0001, 2'b01, 1'b1, 16'h0000, 1'b1, 1});
        vecs.push_back('{16'hFFFD, 16'h0007, 2'b10, 1'b1, 16'hFFEB, 1'b0, 18});
        vecs.push_back('{16'hFF00, 16'h0080, 2'b10, 1'b1, 16'h8000, 1'b0, 18});
        vecs.push_back('{16'hFF00, 16'h0081, 2'b10, 1'b1, 16'h0000, 1'b1, 18});
        vecs.push_back('{16'd300,  16'd300,  2'b10, 1'b0, 16'h0000, 1'b1, 18});
        vecs.push_back('{16'h0000, 16'hFFFB, 2'b10, 1'b1, 16'h0000, 1'b0, 18});
        vecs.push_back('{16'hFFF9, 16'h0002, 2'b11, 1'b1, 16'hFFFD, 1'b0, 18});
        vecs.push_back('{16'hFFFF, 16'h0010, 2'b11, 1'b0, 16'h0FFF, 1'b0, 18});
        vecs.push_back('{16'd7,    16'd0,    2'b11, 1'b0, 16'h0000, 1'b1, 18});
        vecs.push_back('{16'h8000, 16'hFFFF, 2'b11, 1'b1, 16'h0000, 1'b1, 18});
        vecs.push_back('{16'h0000, 16'hFFFD, 2'b11, 1'b1, 16'h0000, 1'b0, 18});

        #2;
        chk("reset_ready",  32'(in_ready),  32'd1);
        chk("reset_valid",  32'(res_valid), 32'd0);
        chk("reset_result", 32'(result),    32'd0);
        chk("reset_error",  32'(error),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sgn, r, e, lat);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
            chk($sformatf("vec%0d_error", i),  32'(e), 32'(vecs[i].err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        for (int i = 0; i < 200; i++) begin
            logic [N-1:0] ra, rb;
            logic [1:0]   rop;
            logic         rs;
            ra = rand_val(); rb = rand_val();
            rop = 2'($urandom_range(0, 3)); rs = 1'($urandom_range(0, 1));
            model(ra, rb, rop, rs, mr, me);
            do_op(ra, rb, rop, rs, r, e, lat);
            chk($sformatf("rand%0d_result op=%0d s=%0d a=%0h b=%0h", i, rop, rs, ra, rb), 32'(r), 32'(mr));
            chk($sformatf("rand%0d_error", i), 32'(e), 32'(me));
            chk($sformatf("rand%0d_latency", i), 32'(lat), (rop[1] ? 32'd18 : 32'd1));
        end

        // Backpressure: result held for 5 cycles while a second request is pulsed.
        @(negedge clk);
        a = 16'd1; b = 16'd2; op = 2'b00; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                a = 16'd10; b = 16'd10; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c),  32'(res_valid), 32'd1);
            chk($sformatf("bp%0d_ready", c),  32'(in_ready),  32'd0);
            chk($sformatf("bp%0d_result", c), 32'(result),    32'd3);
            chk($sformatf("bp%0d_error", c),  32'(error),     32'd0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_release_valid", 32'(res_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        chk("bp_no_extra_valid", 32'(res_valid), 32'd0);
        do_op(16'd4, 16'd5, 2'b00, 1'b0, r, e, lat);
        chk("bp_next_result", 32'(r), 32'd9);

        // Reset at cycle 8 of a multiply aborts it.
        @(negedge clk);
        a = 16'd300; b = 16'd200; op = 2'b10; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid",  32'(res_valid), 32'd0);
        chk("rst_mid_ready",  32'(in_ready),  32'd1);
        chk("rst_mid_result", 32'(result),    32'd0);
        chk("rst_mid_error",  32'(error),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'd100, 16'd7, 2'b11, 1'b0, r, e, lat);
        chk("post_rst_div_result",  32'(r),   32'd14);
        chk("post_rst_div_error",   32'(e),   32'd0);
        chk("post_rst_div_latency", 32'(lat), 32'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calculator_alu.md
Name: calculator_alu

Overview:
Multi-cycle arithmetic unit directly downstream of the calculator control FSM. It accepts one operation (operands A/B, op code, signed flag) per valid/ready handshake. It computes ADD/SUB in one cycle and MUL/DIV iteratively over DATA_WIDTH cycles. It returns an N-bit result plus an error flag through a second valid/ready handshake.

Parameters:
DATA_WIDTH, 16, operand and result width in bits (N); must be >= 4.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_alu_input_a  input  N  operand A (left operand / dividend)
i_alu_input_b  input  N  operand B (right operand / divisor)
i_alu_input_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
i_alu_input_signed  input  1  1: two's complement operands/result, 0: unsigned
i_alu_input_valid  input  1  operation request valid
o_alu_input_ready  output  1  ALU can accept a request
o_alu_result  output  N  result value
o_alu_error  output  1  result invalid (overflow or divide by zero)
o_alu_result_valid  output  1  result/error valid
i_alu_result_ready  input  1  consumer accepts result

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n): state -> IDLE, o_alu_input_ready=1, o_alu_result=0, o_alu_error=0, o_alu_result_valid=0, all internal registers cleared.
- Reset mid-operation aborts the operation with no result produced. The first rising edge after release runs in IDLE.
- FSM states: IDLE, MUL_ITER, DIV_ITER, FINISH, DONE.
- IDLE: o_alu_input_ready=1. On valid&&ready, capture a, b, op and signed. Inputs are ignored at all other times.
  - ADD/SUB: compute and register the result at the same edge; go to DONE.
  - MUL/DIV: load operand magnitudes (absolute value if signed, else raw) and the result sign (a_sign XOR b_sign, signed mode only); clear the N-bit iteration counter; go to MUL_ITER or DIV_ITER.
- MUL_ITER: shift-add, one multiplier bit per cycle, into a 2N-bit accumulator. Go to FINISH after N iterations.
- DIV_ITER: restoring division, one quotient bit per cycle. Go to FINISH after N iterations. Remainder is discarded. A zero divisor still runs the full iteration count.
- FINISH: apply the sign, evaluate the error, register the outputs; go to DONE.
- DONE: o_alu_result_valid=1, o_alu_input_ready=0. o_alu_result and o_alu_error stay stable while i_alu_result_ready=0. On result handshake go to IDLE; o_alu_result_valid drops the next cycle.
- Latency, counting the input-handshake edge as cycle 0:
  - ADD/SUB: o_alu_result_valid high in cycle 1.
  - MUL/DIV: o_alu_result_valid high in cycle N+2.
  - Throughput is one operation per (latency + result handshake). A new input is accepted no earlier than the cycle after the result handshake.
- Error rules. On error, o_alu_result=0 and o_alu_error=1.
  - ADD unsigned: carry out of bit N-1.
  - ADD signed: operands share a sign and the result sign differs.
  - SUB unsigned: A < B (borrow).
  - SUB signed: operand signs differ and the result sign differs from A.
  - MUL unsigned: product >= 2^N.
  - MUL signed: the true signed product lies outside [-2^(N-1), 2^(N-1)-1]. Check the magnitude against 2^(N-1)-1, or 2^(N-1) when the result is negative.
  - DIV: B=0 is an error in both modes. Signed A=-2^(N-1) with B=-1 is an error.
  - Signed DIV truncates toward zero.
- All width rules wrap modulo 2^N internally. The sign of a zero product or quotient is forced positive (never 0x8000 from -0).

Test Plan:
- Unsigned ADD 100+200 (N=16) -> result 300, error 0, valid at cycle 1; unsigned 0xFFFF+1 -> result 0, error 1.
- SUB 5-7: unsigned -> error 1, result 0; signed -> result 0xFFFE, error 0; signed 0x8000-1 -> error 1.
- Signed MUL -3*7 -> 0xFFEB, valid exactly at cycle 18; signed -256*128 -> 0x8000, error 0; unsigned 300*300 -> error 1, result 0.
- Signed DIV -7/2 -> 0xFFFD; unsigned 65535/16 -> 4095; 7/0 -> error 1 at cycle 18; signed 0x8000/0xFFFF -> error 1.
- Backpressure: hold i_alu_result_ready=0 for 5 cycles after valid -> result/error stable, o_alu_input_ready=0, an input pulsed valid during this window is not accepted; release -> ready returns the next cycle.
- Assert rst_n low at cycle 8 of a MUL -> all outputs 0, ready=1 immediately; a following unsigned DIV 100/7 -> result 14, error 0.
